text_writer: RTL
================

# text_writer

Console-style writer that fills the character screen buffer the font renderer reads. Accepts one character per valid/ready handshake, interprets CR/LF/BS, tracks the cursor, and issues single-cycle writes of `{row, col}`-addressed character codes into the buffer's write port. Also clears the whole buffer after reset or on request, and blanks a row on vertical wrap-around.

## Interface
- `cols`, 128: text columns; power of two (1024 / 8-pixel glyph width)
- `rows`, 48: text rows; `log2(rows)` bits address them (768 / 16-pixel glyph height)
- `char_width`, 8: bits per character code
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `char_valid`  in  1  `char_in` holds a character to consume
- `char_in`  in  `char_width`  character code
- `char_ready`  out  1  writer can accept a character this cycle
- `clear`  in  1  single-cycle request to blank the whole buffer
- `buf_we`  out  1  buffer write strobe
- `buf_addr`  out  `log2(cols)+log2(rows)`  write address `{row, col}`
- `buf_data`  out  `char_width`  code to write
- `cursor_x`  out  `log2(cols)`  current column
- `cursor_y`  out  `log2(rows)`  current row
- `busy`  out  1  high during any clear sequence

## Operation
- States: `CLR_ALL`, `CLR_ROW`, `IDLE`.
- `char_ready = (state == IDLE) && !clear`; `busy = (state != IDLE)`.
- **Handshake:** a character is consumed when `char_valid && char_ready` at a rising edge.
- **Codes:**
  - ≥0x20, except 0x7F: write at the cursor, then advance the cursor. Codes with the MSB set are written verbatim.
  - 0x0D (CR): `cursor_x ← 0`.
  - 0x0A (LF): advance the row; `cursor_x` is unchanged.
  - 0x08 (BS): move back one position and write 0x20 there.
  - All other codes: consumed with no effect.
- **Column advance:** `x+1`. At `x = cols-1`: `x ← 0` and advance the row.
- **Row advance:** `y+1`. At `y = rows-1`: `y ← 0`, then enter `CLR_ROW` for row 0.
- **BS boundaries:**
  - At `x = 0, y > 0`: move to `(cols-1, y-1)`.
  - At `(0, 0)`: no move, no write.
- **`CLR_ROW`:** writes 0x20 to `{cursor_y, c}` for `c = 0 .. cols-1`, one per cycle, then returns to `IDLE`. The cursor holds its value throughout.
- **`CLR_ALL`:**
  - Writes 0x20 to addresses 0 .. `cols*rows-1`, one per cycle, in ascending order.
  - Then sets the cursor to (0,0) and returns to `IDLE`.
- **`clear` behaviour:**
  - In `IDLE`: enter `CLR_ALL`. If `char_valid` is high in the same cycle, the character is not consumed.
  - In `CLR_ROW`: abort the row clear and enter `CLR_ALL` from address 0.
  - In `CLR_ALL`: restart from address 0.

## Timing
- **Reset values:**
  - state `CLR_ALL`, clear counter 0, cursor (0,0).
  - `buf_we = 0`, `buf_addr = 0`, `buf_data = 0`.
  - `char_ready = 0`, `busy = 1`.
- `buf_we`, `buf_addr` and `buf_data` are registered. A write for a character accepted at edge N appears during cycle N+1, as a one-cycle pulse.
- `cursor_x`/`cursor_y` update at the accepting edge.
- **Throughput:** one character per cycle in `IDLE`. `char_ready` drops the cycle after a character that triggers row wrap-around.
- `CLR_ROW` lasts exactly `cols` write cycles. `CLR_ALL` lasts exactly `cols*rows` write cycles, each with `buf_we = 1`.
- `char_ready` rises the cycle after the last clear write.
- Asserting `reset` mid-sequence forces reset values immediately. The full clear restarts on release.

## Structure
- Shared header `text_consts.h`:
  - ASCII constants: `CH_SPACE`, `CH_CR`, `CH_LF`, `CH_BS`, `CH_DEL`.
  - State encodings.
  - `log2` comes from `const_funcs.h`.
- One sub-module, `text_clear_seq`:
  - Address counter with start/restart inputs and a mode input: row (`cols` counts at a fixed row) or full (`cols*rows` counts).
  - Outputs address, active and a done pulse.
- Top level holds the cursor, the code decode and the output registers.

## Test plan
All scenarios use `cols = 128`, `rows = 48`, `char_width = 8`.
- **Reset:** release `reset` → `busy` high, 6144 writes of 0x20 to addresses 0..6143, then `char_ready = 1`, cursor (0,0).
- **"AB" then CR:**
  - Writes 0x41 @ 0x0000 and 0x42 @ 0x0001, each one cycle after acceptance.
  - After CR: `cursor_x = 0`, no write issued.
- **Column wrap:** cursor (127,5), send 0x5A → write 0x5A @ `{5,127}` = 0x02FF, cursor (0,6), no stall.
- **Row wrap:** cursor (0,47), send LF → cursor (0,0), `char_ready` low for 128 cycles, 0x20 written to 0x0000..0x007F.
- **Backspace:**
  - BS at (0,3) → write 0x20 @ `{2,127}` = 0x017F, cursor (127,2).
  - BS at (0,0) → no write, cursor unchanged.
- **Clear collisions:**
  - `clear` with `char_valid` in `IDLE` → character not consumed, full clear runs.
  - `clear` mid-`CLR_ROW` → full clear restarts from 0x0000.

Source files
------------

// File: rtl/text_writer_pkg.sv
// rtl/text_writer_pkg.sv - shared constants, widths and state encoding for the text writer
// Purpose: screen geometry, derived address widths, ASCII control codes and FSM states.
// Ports:   none (package).
package text_writer_pkg;

  localparam int COLS       = 128;  // 1024 px / 8 px glyph
  localparam int ROWS       = 48;   // 768 px / 16 px glyph
  localparam int CHAR_WIDTH = 8;

  // Ceiling log2, usable in constant expressions.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int COL_W  = log2(COLS);
  localparam int ROW_W  = log2(ROWS);
  localparam int ADDR_W = COL_W + ROW_W;
  localparam int CELLS  = COLS * ROWS;

  localparam logic [CHAR_WIDTH-1:0] CH_SPACE = CHAR_WIDTH'('h20);
  localparam logic [CHAR_WIDTH-1:0] CH_CR    = CHAR_WIDTH'('h0D);
  localparam logic [CHAR_WIDTH-1:0] CH_LF    = CHAR_WIDTH'('h0A);
  localparam logic [CHAR_WIDTH-1:0] CH_BS    = CHAR_WIDTH'('h08);
  localparam logic [CHAR_WIDTH-1:0] CH_DEL   = CHAR_WIDTH'('h7F);

  typedef enum logic [1:0] {
    ST_CLR_ALL = 2'd0,
    ST_CLR_ROW = 2'd1,
    ST_IDLE    = 2'd2
  } state_e;

endpackage

// File: rtl/text_writer_if.sv
// rtl/text_writer_if.sv - character stream and buffer write port bundle
// Purpose: groups the character handshake, clear request, buffer write port and status.
// Ports:   master = host side (drives char_valid/char_in/clear),
//          slave  = writer side (drives char_ready, buf_*, cursor_*, busy).
interface text_writer_if;
  import text_writer_pkg::*;

  logic                  char_valid;
  logic [CHAR_WIDTH-1:0] char_in;
  logic                  char_ready;
  logic                  clear;
  logic                  buf_we;
  logic [ADDR_W-1:0]     buf_addr;
  logic [CHAR_WIDTH-1:0] buf_data;
  logic [COL_W-1:0]      cursor_x;
  logic [ROW_W-1:0]      cursor_y;
  logic                  busy;

  modport master (
    output char_valid, char_in, clear,
    input  char_ready, buf_we, buf_addr, buf_data, cursor_x, cursor_y, busy
  );

  modport slave (
    input  char_valid, char_in, clear,
    output char_ready, buf_we, buf_addr, buf_data, cursor_x, cursor_y, busy
  );

endinterface

// File: rtl/text_writer_clear_seq.sv
// rtl/text_writer_clear_seq.sv - address counter for row and full-screen clears
// Purpose: steps one address per cycle, either across one row or the whole buffer.
// Ports:   clk, reset (async, active-low), start (load 0 and run), start_full (mode
//          sampled with start), row (fixed row for row mode), addr, active, done
//          (high in the cycle the last address is presented).
module text_writer_clear_seq
  import text_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_full,
  input  logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              active,
  output logic              done
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              full_q, full_d;
  logic              at_last;

  assign at_last = full_q ? (cnt_q == ADDR_W'(CELLS - 1))
                          : (cnt_q == ADDR_W'(COLS - 1));

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    full_d   = full_q;
    if (start) begin
      cnt_d    = '0;
      active_d = 1'b1;
      full_d   = start_full;
    end else if (active_q) begin
      if (at_last) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  // Row mode keeps the row bits from the caller and walks only the column bits.
  assign addr   = full_q ? cnt_q : {row, cnt_q[COL_W-1:0]};
  assign active = active_q;
  assign done   = active_q && at_last && !start;

  // Out of reset the buffer contents are unknown, so a full clear is already running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
      full_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      full_q   <= full_d;
    end
  end

endmodule

// File: rtl/text_writer.sv
// rtl/text_writer.sv - console-style writer into the character screen buffer
// Purpose: consumes one character per handshake, interprets CR/LF/BS, tracks the
//          cursor and issues registered single-cycle buffer writes; runs full and
//          row clears through text_writer_clear_seq.
// Ports:   clk, reset (async, active-low), tw (slave side of text_writer_if).
module text_writer
  import text_writer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  text_writer_if.slave tw
);

  state_e                state_q, state_d;
  logic [COL_W-1:0]      x_q, x_d;
  logic [ROW_W-1:0]      y_q, y_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CHAR_WIDTH-1:0] data_q, data_d;

  logic                  seq_start;
  logic                  seq_full;
  logic [ADDR_W-1:0]     seq_addr;
  logic                  seq_active;
  logic                  seq_done;

  logic [CHAR_WIDTH-1:0] c;
  logic                  col_last;
  logic                  row_last;
  logic                  adv_row;

  assign c        = tw.char_in;
  assign col_last = (x_q == COL_W'(COLS - 1));
  assign row_last = (y_q == ROW_W'(ROWS - 1));

  text_writer_clear_seq u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .start      (seq_start),
    .start_full (seq_full),
    .row        (y_q),
    .addr       (seq_addr),
    .active     (seq_active),
    .done       (seq_done)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    seq_start = 1'b0;
    seq_full  = 1'b0;
    adv_row   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // clear has priority; char_ready is low so the character stays pending.
        if (tw.clear) begin
          state_d   = ST_CLR_ALL;
          seq_start = 1'b1;
          seq_full  = 1'b1;
        end else if (tw.char_valid) begin
          if (c == CH_CR) begin
            x_d = '0;
          end else if (c == CH_LF) begin
            adv_row = 1'b1;
          end else if (c == CH_BS) begin
            if (x_q != '0) begin
              x_d    = x_q - COL_W'(1);
              we_d   = 1'b1;
              addr_d = {y_q, x_q - COL_W'(1)};
              data_d = CH_SPACE;
            end else if (y_q != '0) begin
              x_d    = COL_W'(COLS - 1);
              y_d    = y_q - ROW_W'(1);
              we_d   = 1'b1;
              addr_d = {y_q - ROW_W'(1), COL_W'(COLS - 1)};
              data_d = CH_SPACE;
            end
          end else if ((c >= CH_SPACE) && (c != CH_DEL)) begin
            we_d   = 1'b1;
            addr_d = {y_q, x_q};
            data_d = c;
            if (col_last) begin
              x_d     = '0;
              adv_row = 1'b1;
            end else begin
              x_d = x_q + COL_W'(1);
            end
          end
        end
      end

      default: begin
        // A clear request during any clear sequence restarts a full clear at 0;
        // no write is issued in the restart cycle.
        if (tw.clear) begin
          state_d   = ST_CLR_ALL;
          seq_start = 1'b1;
          seq_full  = 1'b1;
        end else if (seq_active) begin
          we_d   = 1'b1;
          addr_d = seq_addr;
          data_d = CH_SPACE;
          if (seq_done) begin
            state_d = ST_IDLE;
            if (state_q == ST_CLR_ALL) begin
              x_d = '0;
              y_d = '0;
            end
          end
        end
      end
    endcase

    // Wrapping past the bottom row scrolls back to row 0, which must be blanked;
    // the sequencer reads y_q, already 0 by the time it starts stepping.
    if (adv_row) begin
      if (row_last) begin
        y_d       = '0;
        state_d   = ST_CLR_ROW;
        seq_start = 1'b1;
      end else begin
        y_d = y_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLR_ALL;
      x_q     <= '0;
      y_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign tw.char_ready = (state_q == ST_IDLE) && !tw.clear;
  assign tw.busy       = (state_q != ST_IDLE);
  assign tw.buf_we     = we_q;
  assign tw.buf_addr   = addr_q;
  assign tw.buf_data   = data_q;
  assign tw.cursor_x   = x_q;
  assign tw.cursor_y   = y_q;

endmodule
